// File: rtl/gray_seq_ctrl_pkg.sv
// Purpose: shared types and constants for the Gray-code sequence controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: sequencer state enumeration and count-direction constants.
package gray_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/binary2gray.sv
// Purpose: parameterised binary to reflected-Gray converter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: bin (N-bit binary in), gray (N-bit Gray out).
module binary2gray #(
  parameter int N = 4
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  // MSB passes through; each lower bit is the XOR of itself and its upper neighbour.
  assign gray = {bin[N-1], bin[N-1:1] ^ bin[N-2:0]};

endmodule

// File: rtl/gray_seq_ctrl.sv
// Purpose: steps a binary index up or down and presents it with its Gray code, single pass or looping.
// Latency: first code valid one cycle after an accepted start; gray_out has zero skew to bin_out.
// Backpressure: out_ready low holds bin_out/gray_out stable; a code advances only on out_valid & out_ready.
// Ports: clk, rst_n (async active-low); start/abort/dir/cont control; out_valid/out_ready handshake;
//        bin_out/gray_out code; busy (not IDLE), done (single pass finished), wrap (continuous loop restarted).
module gray_seq_ctrl
  import gray_seq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         dir,
  input  logic         cont,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [N-1:0] bin_out,
  output logic [N-1:0] gray_out,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ALL_ZERO = {N{1'b0}};

  state_t       state;
  logic         dir_q;
  logic         cont_q;
  logic [N-1:0] first_code;
  logic [N-1:0] term_code;
  logic [N-1:0] bin_step;
  logic         is_term;
  logic         xfer;

  assign first_code = (dir_q == DIR_DOWN) ? ALL_ONES : ALL_ZERO;
  assign term_code  = (dir_q == DIR_DOWN) ? ALL_ZERO : ALL_ONES;
  assign bin_step   = (dir_q == DIR_DOWN) ? (bin_out - {{(N-1){1'b0}}, 1'b1})
                                          : (bin_out + {{(N-1){1'b0}}, 1'b1});
  assign is_term    = (bin_out == term_code);

  // out_valid is only ever set while in EMIT, so this is a handshake in EMIT.
  assign xfer = out_valid & out_ready;

  // wrap must coincide with the transfer of the terminal code, so it cannot be
  // registered; abort on the same cycle suppresses it.
  assign wrap = xfer & ~abort & is_term & cont_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_out   <= ALL_ZERO;
      dir_q     <= DIR_UP;
      cont_q    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A simultaneous abort cancels the start request.
          if (start && !abort) begin
            bin_out   <= (dir == DIR_DOWN) ? ALL_ONES : ALL_ZERO;
            dir_q     <= dir;
            cont_q    <= cont;
            state     <= EMIT;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        EMIT: begin
          if (abort) begin
            // Any coincident transfer is consumed without advancing the index.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (xfer) begin
            if (!is_term) begin
              bin_out <= bin_step;
            end else if (cont_q) begin
              bin_out <= first_code;
            end else begin
              state     <= DONE;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          // DONE always lasts one cycle; abort here leads to the same exit.
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  binary2gray #(
    .N (N)
  ) u_b2g (
    .bin  (bin_out),
    .gray (gray_out)
  );

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Purpose: directed checks of gray_seq_ctrl with N=4 against hand-derived code sequences.
// Latency: inputs driven 1 time unit after the rising edge; outputs sampled before the falling edge.
// Backpressure: out_ready is driven directly to exercise stalls.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dir = 1'b0;
  logic       cont = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] bin_out;
  logic [3:0] gray_out;
  logic       busy;
  logic       done;
  logic       wrap;

  int vectors = 0;
  int miscompares = 0;

  // Hand-written 4-bit reflected Gray sequence for indices 0..15.
  localparam logic [3:0] GT [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_seq_ctrl #(.N(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .cont      (cont),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({out_valid, busy, done, wrap, bin_out, gray_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 0", {out_valid, busy, done, wrap, bin_out, gray_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    next();
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_single_up();
    start = 1'b1; dir = 1'b0; cont = 1'b0; out_ready = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL up_cycle0_busy: got %b want 0", busy);
    end
    next();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      vectors++;
      if ({out_valid, busy, done, wrap, bin_out, gray_out} !== {4'b1100, 4'(i), GT[i]}) begin
        miscompares++;
        $display("FAIL up_code[%0d]: got v=%b b=%b d=%b w=%b bin=%h gray=%h want v=1 b=1 d=0 w=0 bin=%h gray=%h",
                 i, out_valid, busy, done, wrap, bin_out, gray_out, 4'(i), GT[i]);
      end
      next();
    end
    vectors++;
    if ({out_valid, done, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL up_done_cycle17: got v/d/busy=%b want 011", {out_valid, done, busy});
    end
    next();
    vectors++;
    if ({out_valid, done, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL up_idle_cycle18: got v/d/busy=%b want 000", {out_valid, done, busy});
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1; dir = 1'b0; cont = 1'b0; out_ready = 1'b1;
    next();
    start = 1'b0;
    repeat (5) next();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({out_valid, bin_out, gray_out} !== {1'b1, 4'h5, 4'b0111}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got v=%b bin=%h gray=%b want v=1 bin=5 gray=0111",
                 i, out_valid, bin_out, gray_out);
      end
      next();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (gray_out !== 4'b0111) begin
      miscompares++;
      $display("FAIL bp_release_same: got %b want 0111", gray_out);
    end
    next();
    vectors++;
    if ({bin_out, gray_out} !== {4'h6, 4'b0101}) begin
      miscompares++;
      $display("FAIL bp_step: got bin=%h gray=%b want bin=6 gray=0101", bin_out, gray_out);
    end
    abort = 1'b1;
    next();
    abort = 1'b0;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL bp_abort: got v/busy/d=%b want 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_down_cont();
    logic [3:0] exp_b;
    logic [3:0] prev_g;
    prev_g = 4'h0;
    start = 1'b1; dir = 1'b1; cont = 1'b1; out_ready = 1'b1;
    next();
    start = 1'b0; dir = 1'b0; cont = 1'b0;  // must already be latched
    for (int i = 0; i < 18; i++) begin
      exp_b = 4'(15 - (i % 16));
      #1;
      vectors++;
      if ({out_valid, done, wrap, bin_out, gray_out} !== {1'b1, 1'b0, (i == 15), exp_b, exp_b ^ (exp_b >> 1)}) begin
        miscompares++;
        $display("FAIL down_code[%0d]: got v=%b d=%b w=%b bin=%h gray=%h want v=1 d=0 w=%b bin=%h gray=%h",
                 i, out_valid, done, wrap, bin_out, gray_out, (i == 15), exp_b, exp_b ^ (exp_b >> 1));
      end
      if (i > 0) begin
        vectors++;
        if ($countones(prev_g ^ gray_out) != 1) begin
          miscompares++;
          $display("FAIL down_one_bit[%0d]: got %0d bits changed want 1", i, $countones(prev_g ^ gray_out));
        end
      end
      prev_g = gray_out;
      next();
    end
    abort = 1'b1;
    next();
    abort = 1'b0;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL down_abort: got v/busy/d=%b want 000", {out_valid, busy, done});
    end
  endtask

  task automatic test_abort_transfer();
    start = 1'b1; dir = 1'b0; cont = 1'b0; out_ready = 1'b1;
    next();
    start = 1'b0;
    repeat (7) next();
    abort = 1'b1;
    #1;
    vectors++;
    if ({bin_out, wrap} !== {4'h7, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_pre: got bin=%h w=%b want bin=7 w=0", bin_out, wrap);
    end
    next();
    abort = 1'b0;
    vectors++;
    if ({out_valid, busy, done, bin_out} !== {3'b000, 4'h7}) begin
      miscompares++;
      $display("FAIL abort_next: got v/busy/d=%b bin=%h want 000 bin=7", {out_valid, busy, done}, bin_out);
    end
    next();
    vectors++;
    if ({out_valid, done, bin_out} !== {2'b00, 4'h7}) begin
      miscompares++;
      $display("FAIL abort_after: got v/d=%b bin=%h want 00 bin=7", {out_valid, done}, bin_out);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; dir = 1'b0; cont = 1'b0; out_ready = 1'b1;
    next();
    start = 1'b0;
    repeat (3) next();
    vectors++;
    if (bin_out !== 4'h3) begin
      miscompares++;
      $display("FAIL areset_pre: got bin=%h want 3", bin_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, busy, done, wrap, bin_out, gray_out} !== 12'h000) begin
      miscompares++;
      $display("FAIL areset_immediate: got %b want 0", {out_valid, busy, done, wrap, bin_out, gray_out});
    end
    @(negedge clk);
    rst_n = 1'b1;
    next();
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL areset_await: got v/busy=%b want 00", {out_valid, busy});
    end
    start = 1'b1;
    next();
    start = 1'b0;
    vectors++;
    if ({out_valid, bin_out, gray_out} !== {1'b1, 4'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL areset_restart: got v=%b bin=%h gray=%h want v=1 bin=0 gray=0", out_valid, bin_out, gray_out);
    end
    next();
    vectors++;
    if (bin_out !== 4'h1) begin
      miscompares++;
      $display("FAIL areset_step: got bin=%h want 1", bin_out);
    end
    abort = 1'b1;
    next();
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    start = 1'b1; dir = 1'b0; cont = 1'b0; out_ready = 1'b1;
    next();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        start = 1'b1; dir = 1'b1; cont = 1'b1;
      end else begin
        start = 1'b0; dir = 1'b0; cont = 1'b0;
      end
      #1;
      vectors++;
      if ({out_valid, bin_out, gray_out} !== {1'b1, 4'(i), GT[i]}) begin
        miscompares++;
        $display("FAIL ign_code[%0d]: got v=%b bin=%h gray=%h want v=1 bin=%h gray=%h",
                 i, out_valid, bin_out, gray_out, 4'(i), GT[i]);
      end
      next();
    end
    start = 1'b1;
    #1;
    vectors++;
    if ({out_valid, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL ign_done: got v/d=%b want 01", {out_valid, done});
    end
    next();
    start = 1'b0;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL ign_idle: got v/busy/d=%b want 000", {out_valid, busy, done});
    end
    next();
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL ign_stay_idle: got v/busy=%b want 00", {out_valid, busy});
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1; dir = 1'b0;
    next();
    start = 1'b0; abort = 1'b0;
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_start_abort: got v/busy=%b want 00", {out_valid, busy});
    end
    abort = 1'b1;
    next();
    abort = 1'b0;
    vectors++;
    if ({out_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_abort: got v/busy=%b want 00", {out_valid, busy});
    end
    start = 1'b1;
    next();
    start = 1'b0;
    vectors++;
    if ({out_valid, busy, bin_out} !== {2'b11, 4'h0}) begin
      miscompares++;
      $display("FAIL idle_start_after: got v/busy=%b bin=%h want 11 bin=0", {out_valid, busy}, bin_out);
    end
    abort = 1'b1;
    next();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_backpressure();
    test_down_cont();
    test_abort_transfer();
    test_async_reset();
    test_start_ignored();
    test_start_abort_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning code width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a sequence; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminates an active sequence.
REQ-006 SHALL have port dir  input  1  0 = count up, 1 = count down; latched on an accepted start.
REQ-007 SHALL have port cont  input  1  1 = loop continuously, 0 = single pass; latched on an accepted start.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the current code.
REQ-009 SHALL have port out_valid  output  1  gray_out and bin_out are valid.
REQ-010 SHALL have port bin_out  output  N  current binary index (register).
REQ-011 SHALL have port gray_out  output  N  Gray code of bin_out.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a single pass completes.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse when a continuous sequence wraps.

Function
REQ-015 SHALL implement the states IDLE, EMIT and DONE.
REQ-016 IDLE, start=1: SHALL load bin_out with 0 (dir=0) or 2^N-1 (dir=1), latch dir and cont, and enter EMIT; out_valid SHALL be 1 on the next cycle.
REQ-017 gray_out SHALL equal {bin[N-1], bin[N-1:1] ^ bin[N-2:0]}, derived combinationally from the bin_out register, with zero-cycle skew to bin_out.
REQ-018 EMIT: out_valid SHALL be 1, and a transfer SHALL occur on any cycle with out_valid & out_ready.
REQ-019 Backpressure: while out_ready=0, bin_out and gray_out SHALL hold stable.
REQ-020 A transfer of a non-terminal code SHALL step bin_out by +1 (up) or -1 (down) modulo 2^N.
REQ-021 Terminal code SHALL be 2^N-1 (up) or 0 (down).
REQ-022 Transfer of the terminal code with cont=1: bin_out SHALL reload the first code, wrap SHALL pulse in the same cycle, and the state SHALL remain EMIT.
REQ-023 Transfer of the terminal code with cont=0: the next state SHALL be DONE and out_valid SHALL be 0 on the next cycle.
REQ-024 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-025 abort in EMIT or DONE: the next state SHALL be IDLE, out_valid SHALL drop next cycle, and no done or wrap pulse SHALL occur.
REQ-026 abort with a simultaneous transfer: abort SHALL win; the transfer counts as consumed, but bin_out SHALL NOT advance and no wrap/done SHALL fire.
REQ-027 start asserted outside IDLE SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-028 start and abort together in IDLE: start SHALL be ignored.
REQ-029 Consecutive transferred gray_out values SHALL differ in exactly one bit, including across a wrap.
REQ-030 A single pass SHALL transfer exactly 2^N codes.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE and bin_out, out_valid, busy, done, wrap, and the latched dir and cont to 0 (gray_out = 0).
REQ-032 Reset asserted mid-sequence SHALL discard the sequence; after release the block SHALL await a new start.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE, EMIT, DONE) and the direction constants DIR_UP=0, DIR_DOWN=1.
REQ-034 The Gray conversion SHALL be one instance of the existing parameterised binary2gray sub-module (N passed through); no other sub-modules.

Verification
REQ-035 N=4, dir=0, cont=0, out_ready=1, start pulse at cycle 0: out_valid SHALL be 1 from cycle 1 to cycle 16 with gray_out = 0000, 0001, 0011, 0010, 0110, ..., 1000; done SHALL pulse at cycle 17; busy SHALL be 0 at cycle 18.
REQ-036 Backpressure, with out_ready low for 3 cycles at bin_out=5: gray_out=0111 SHALL hold for 3 cycles, then step to 0101.
REQ-037 dir=1, cont=1: after 16 transfers from 1111 (gray 1000), wrap SHALL pulse on the transfer of 0000 and the next code SHALL be 1111; done SHALL never assert.
REQ-038 abort asserted together with a transfer at bin_out=7: the next cycle SHALL have out_valid=0, state IDLE and bin_out=7, with no done pulse.
REQ-039 rst_n pulled low mid-sequence, asynchronously between clock edges: all outputs SHALL read 0 immediately; after release, a start SHALL restart from 0000.
REQ-040 start pulses during EMIT and during DONE SHALL have no effect, and the sequence SHALL complete unchanged.
